// File: rtl/secded_err_monitor.sv
// SECDED error monitor: saturating SEC/DED counters, health FSM and an optional event FIFO.
// Define SECDED_EVT_FIFO_EN to build the first-word-fall-through event FIFO and overflow flag.
module secded_err_monitor #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ALARM_THRESH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [3:0]       i_data,
  input  logic [2:0]       i_syndrome,
  input  logic             i_1bit_error,
  input  logic             i_2bit_error,
  input  logic             i_parity_error,
  input  logic             i_clr,
  input  logic             i_evt_rd,
  output logic             o_evt_valid,
  output logic [7:0]       o_evt_data,
  output logic             o_evt_overflow,
  output logic [CNT_W-1:0] o_sec_cnt,
  output logic [CNT_W-1:0] o_ded_cnt,
  output logic [1:0]       o_state,
  output logic             o_alarm
);

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_DEGRADED = 2'b01;
  localparam logic [1:0] ST_FAILED   = 2'b10;

  logic sec_evt;
  logic ded_evt;
  logic unused_parity;

  // A double-bit flag dominates: a sample with both flags set is a DED event.
  assign sec_evt       = i_valid & i_1bit_error & ~i_2bit_error;
  assign ded_evt       = i_valid & i_2bit_error;
  assign unused_parity = i_parity_error;

  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;
  logic [1:0]       state_q, state_d;
  logic             alarm_q;

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    state_d   = state_q;
    if (sec_evt && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + 1'b1;
    if (ded_evt && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + 1'b1;
    case (state_q)
      ST_OK: begin
        if (ded_evt)      state_d = ST_FAILED;
        else if (sec_evt) state_d = ST_DEGRADED;
      end
      ST_DEGRADED: begin
        if (ded_evt) state_d = ST_FAILED;
        else if (sec_evt && (32'(sec_cnt_d) >= ALARM_THRESH)) state_d = ST_FAILED;
      end
      default: state_d = ST_FAILED;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
      state_q   <= ST_OK;
      alarm_q   <= 1'b0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
      state_q   <= state_d;
      alarm_q   <= (state_d == ST_FAILED);
    end
  end

  assign o_sec_cnt = sec_cnt_q;
  assign o_ded_cnt = ded_cnt_q;
  assign o_state   = state_q;
  assign o_alarm   = alarm_q;

`ifdef SECDED_EVT_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             ovf_q;
  logic             push, pop, full, push_ok;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
  assign push    = sec_evt | ded_evt;
  assign pop     = i_evt_rd & (count_q != '0);
  assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push_ok = push & (~full | pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_clr && push_ok) mem_q[wr_ptr_q] <= {ded_evt, i_syndrome, i_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  assign o_evt_valid    = (count_q != '0);
  assign o_evt_data     = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign o_evt_overflow = ovf_q;
`else
  logic unused_fifo;

  assign unused_fifo    = ^{i_evt_rd, i_data, i_syndrome, (FIFO_DEPTH != 0)};
  assign o_evt_valid    = 1'b0;
  assign o_evt_data     = '0;
  assign o_evt_overflow = 1'b0;
`endif

endmodule
